branch_resolve_unit: RTL and testbench

Consumer side of the branch comparator in the pipelined RV32I core. Sits at the EX stage. It takes the comparator's `less`/`equal` flags and the branch funct3, decides the actual branch direction, and drives `o_br_un` back to the comparator. It also provides a 2-bit-counter direction predictor to IF, detects mispredictions, and issues a registered PC redirect plus a multi-cycle IF/ID flush. Misprediction statistics counters are included.

---
 rtl/brc_pkg.sv | 26 ++
 rtl/bht.sv | 49 ++++
 rtl/branch_resolve_unit.sv | 161 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/brc_pkg.sv
// Shared definitions for the EX-stage branch resolve unit.
//   - RV32I conditional-branch funct3 encodings
//   - 2-bit saturating direction counter type and its four states
//   - resolve FSM state encoding
package brc_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_e;

endpackage

// File: rtl/bht.sv
// Branch history table: an array of 2-bit saturating direction counters.
// Ports:
//   i_clk, i_reset : clock and synchronous active-high reset (all entries -> WNT)
//   i_rd_idx       : combinational read index
//   o_rd_ctr       : counter at i_rd_idx (pre-update value, no write bypass)
//   i_wr_en        : apply one update at the next rising edge
//   i_wr_idx       : index of the entry to update
//   i_wr_taken     : resolved direction; counter moves toward ST or SNT
module bht
  import brc_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IW      = $clog2(ENTRIES)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [IW-1:0] i_rd_idx,
  output ctr_t          o_rd_ctr,
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_idx,
  input  logic          i_wr_taken
);

  ctr_t ctr_q [ENTRIES];
  ctr_t wrCur;
  ctr_t wrNext_d;

  assign o_rd_ctr = ctr_q[i_rd_idx];
  assign wrCur    = ctr_q[i_wr_idx];

  // Saturate at ST when taken and at SNT when not taken.
  always_comb begin
    wrNext_d = wrCur;
    if (i_wr_taken) begin
      if (wrCur != ST) wrNext_d = wrCur + 2'd1;
    end else begin
      if (wrCur != SNT) wrNext_d = wrCur - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
    end else if (i_wr_en) begin
      ctr_q[i_wr_idx] <= wrNext_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolve unit for the pipelined RV32I core.
// Decides the real branch direction from the comparator flags, drives the
// unsigned-compare select back to the comparator, predicts direction for
// fetch from a BHT, detects mispredictions and issues a registered redirect
// followed by a multi-cycle IF/ID flush. Keeps branch/mispredict statistics.
// Ports:
//   i_clk, i_reset                 : clock, synchronous active-high reset
//   i_if_pc / o_if_pred_taken      : fetch-side prediction lookup (combinational)
//   i_ex_valid, i_ex_is_br         : EX holds a real conditional branch
//   i_ex_funct3, i_ex_pc           : branch kind and its PC
//   i_ex_target                    : computed taken target
//   i_ex_pred_taken/_pred_target   : what fetch actually did after this branch
//   o_br_un                        : unsigned compare select (combinational)
//   i_br_less, i_br_equal          : comparator flags
//   o_redirect_valid/_pc           : one-cycle registered redirect request
//   o_flush                        : registered IF/ID kill, FLUSH_CYC cycles long
//   o_br_illegal                   : one-cycle pulse for funct3 010/011
//   o_br_count, o_mispred_count    : wrapping statistics counters
module branch_resolve_unit
  import brc_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int FLUSH_CYC   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_if_pc,
  output logic        o_if_pred_taken,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_br,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic        o_br_un,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic        o_br_illegal,
  output logic [31:0] o_br_count,
  output logic [31:0] o_mispred_count
);

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

  state_e      state_q;
  logic [2:0]  flushCnt_q;
  logic        flush_q;
  logic        redirValid_q;
  logic [31:0] redirPc_q;
  logic        illegal_q;
  logic [31:0] brCount_q;
  logic [31:0] mispredCount_q;

  logic        taken;
  logic        f3Legal;
  logic        resolve;
  logic        legalRes;
  logic        illegalRes;
  logic        mispred;
  logic [31:0] redirPc_d;
  ctr_t        ifCtr;
  logic        unusedIfPc;

  assign o_br_un = i_ex_funct3[1];

  // Only the index bits of the fetch PC reach the predictor.
  assign unusedIfPc = ^{i_if_pc[31:IW+2], i_if_pc[1:0]};

  // Direction decode; 010 and 011 are not branch encodings.
  always_comb begin
    taken   = 1'b0;
    f3Legal = 1'b1;
    case (i_ex_funct3)
      F3_BEQ:           taken = i_br_equal;
      F3_BNE:           taken = !i_br_equal;
      F3_BLT, F3_BLTU:  taken = i_br_less;
      F3_BGE, F3_BGEU:  taken = !i_br_less;
      default:          f3Legal = 1'b0;
    endcase
  end

  // While flushing, the EX stage carries wrong-path work and is ignored.
  assign resolve    = i_ex_valid & i_ex_is_br & (state_q == IDLE);
  assign legalRes   = resolve & f3Legal;
  assign illegalRes = resolve & !f3Legal;

  // A taken branch is also wrong if fetch followed a different target.
  assign mispred = legalRes &
                   ((taken != i_ex_pred_taken) |
                    (taken & (i_ex_target != i_ex_pred_target)));

  assign redirPc_d = taken ? i_ex_target : (i_ex_pc + 32'd4);

  bht #(
    .ENTRIES (BHT_ENTRIES),
    .IW      (IW)
  ) u_bht (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rd_idx   (i_if_pc[IW+1:2]),
    .o_rd_ctr   (ifCtr),
    .i_wr_en    (legalRes),
    .i_wr_idx   (i_ex_pc[IW+1:2]),
    .i_wr_taken (taken)
  );

  assign o_if_pred_taken = ifCtr[1];

  // Resolve FSM with registered redirect/flush/illegal outputs and counters.
  // The flush counter is loaded with FLUSH_CYC-1 so that o_flush stays high
  // for exactly FLUSH_CYC cycles, the last one being the cycle where it hits 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= IDLE;
      flushCnt_q     <= 3'd0;
      flush_q        <= 1'b0;
      redirValid_q   <= 1'b0;
      redirPc_q      <= 32'd0;
      illegal_q      <= 1'b0;
      brCount_q      <= 32'd0;
      mispredCount_q <= 32'd0;
    end else begin
      redirValid_q <= mispred;
      illegal_q    <= illegalRes;
      if (mispred)  redirPc_q      <= redirPc_d;
      if (legalRes) brCount_q      <= brCount_q + 32'd1;
      if (mispred)  mispredCount_q <= mispredCount_q + 32'd1;
      case (state_q)
        IDLE: begin
          if (mispred) begin
            state_q    <= FLUSH;
            flushCnt_q <= FLUSH_LOAD;
            flush_q    <= 1'b1;
          end
        end
        FLUSH: begin
          if (flushCnt_q == 3'd0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            flushCnt_q <= flushCnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_redirect_valid = redirValid_q;
  assign o_redirect_pc    = redirPc_q;
  assign o_flush          = flush_q;
  assign o_br_illegal     = illegal_q;
  assign o_br_count       = brCount_q;
  assign o_mispred_count  = mispredCount_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit. Stimulus pushes expected
// redirects, flush lengths and illegal pulses into queues; a monitor on the
// falling edge pops and compares whenever the DUT presents one of them.
module tb_branch_resolve_unit;

  localparam int BHT_ENTRIES = 128;
  localparam int FLUSH_CYC   = 2;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_if_pc;
  logic        o_if_pred_taken;
  logic        i_ex_valid;
  logic        i_ex_is_br;
  logic [2:0]  i_ex_funct3;
  logic [31:0] i_ex_pc;
  logic [31:0] i_ex_target;
  logic        i_ex_pred_taken;
  logic [31:0] i_ex_pred_target;
  logic        o_br_un;
  logic        i_br_less;
  logic        i_br_equal;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        o_flush;
  logic        o_br_illegal;
  logic [31:0] o_br_count;
  logic [31:0] o_mispred_count;

  int checks = 0;
  int errors = 0;
  int expBr  = 0;
  int expMis = 0;
  bit monitorOn = 1'b0;
  int flushRun = 0;

  logic [31:0] redirQ [$];
  int          flushQ [$];
  bit          illQ   [$];

  branch_resolve_unit #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .FLUSH_CYC   (FLUSH_CYC)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_if_pc          (i_if_pc),
    .o_if_pred_taken  (o_if_pred_taken),
    .i_ex_valid       (i_ex_valid),
    .i_ex_is_br       (i_ex_is_br),
    .i_ex_funct3      (i_ex_funct3),
    .i_ex_pc          (i_ex_pc),
    .i_ex_target      (i_ex_target),
    .i_ex_pred_taken  (i_ex_pred_taken),
    .i_ex_pred_target (i_ex_pred_target),
    .o_br_un          (o_br_un),
    .i_br_less        (i_br_less),
    .i_br_equal       (i_br_equal),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc),
    .o_flush          (o_flush),
    .o_br_illegal     (o_br_illegal),
    .o_br_count       (o_br_count),
    .o_mispred_count  (o_mispred_count)
  );

  always #5 i_clk = ~i_clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Drive one EX-stage branch for one cycle and record what must follow.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] pc,
                               input logic [31:0] tgt, input logic pt,
                               input logic [31:0] ptgt, input logic less,
                               input logic eq, input logic expMisp,
                               input logic [31:0] expPc, input int expFlush,
                               input logic expIll, input logic counted);
    i_ex_valid       = 1'b1;
    i_ex_is_br       = 1'b1;
    i_ex_funct3      = f3;
    i_ex_pc          = pc;
    i_ex_target      = tgt;
    i_ex_pred_taken  = pt;
    i_ex_pred_target = ptgt;
    i_br_less        = less;
    i_br_equal       = eq;
    #1;
    checkOutput("br_un", {31'd0, o_br_un}, {31'd0, f3[1]});
    @(posedge i_clk);
    if (expMisp) begin
      redirQ.push_back(expPc);
      flushQ.push_back(expFlush);
      expMis++;
    end
    if (counted) expBr++;
    if (expIll) illQ.push_back(1'b1);
    #1;
    i_ex_valid = 1'b0;
    i_ex_is_br = 1'b0;
  endtask

  task automatic checkPred(input logic [31:0] pc, input logic exp);
    i_if_pc = pc;
    #1;
    checkOutput($sformatf("pred_taken@%08h", pc), {31'd0, o_if_pred_taken}, {31'd0, exp});
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_br_count"}, o_br_count, 32'(expBr));
    checkOutput({tag, "_mispred_count"}, o_mispred_count, 32'(expMis));
  endtask

  // Monitor: compare every presented redirect, illegal pulse and flush run.
  always @(negedge i_clk) begin
    if (monitorOn) begin
      if (o_redirect_valid) begin
        checks++;
        if (redirQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_redirect: got pc 0x%08h, expected none", o_redirect_pc);
        end else begin
          logic [31:0] e;
          e = redirQ.pop_front();
          if (o_redirect_pc !== e) begin
            errors++;
            $display("[TB] FAIL redirect_pc: got 0x%08h, expected 0x%08h", o_redirect_pc, e);
          end
        end
      end
      if (o_br_illegal) begin
        checks++;
        if (illQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_illegal: got pulse, expected none");
        end else begin
          void'(illQ.pop_front());
        end
      end
      if (o_flush) begin
        flushRun++;
      end else if (flushRun > 0) begin
        checks++;
        if (flushQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_flush: got %0d cycles, expected none", flushRun);
        end else begin
          int e;
          e = flushQ.pop_front();
          if (flushRun != e) begin
            errors++;
            $display("[TB] FAIL flush_len: got %0d cycles, expected %0d", flushRun, e);
          end
        end
        flushRun = 0;
      end
    end
  end

  initial begin
    i_reset = 1'b1;
    i_if_pc = 32'h0;
    i_ex_valid = 1'b0;
    i_ex_is_br = 1'b0;
    i_ex_funct3 = 3'b000;
    i_ex_pc = 32'h0;
    i_ex_target = 32'h0;
    i_ex_pred_taken = 1'b0;
    i_ex_pred_target = 32'h0;
    i_br_less = 1'b0;
    i_br_equal = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    monitorOn = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_redirect_valid", {31'd0, o_redirect_valid}, 32'd0);
    checkOutput("rst_redirect_pc", o_redirect_pc, 32'd0);
    checkOutput("rst_flush", {31'd0, o_flush}, 32'd0);
    checkOutput("rst_illegal", {31'd0, o_br_illegal}, 32'd0);
    checkCounters("rst");
    checkPred(32'h100, 1'b0);

    $display("[TB] BEQ taken mispredict, then wrong-path branch during flush");
    applyStimulus(3'b000, 32'h100, 32'h140, 1'b0, 32'h104, 1'b0, 1'b1,
                  1'b1, 32'h140, FLUSH_CYC, 1'b0, 1'b1);
    checkOutput("flush_n1", {31'd0, o_flush}, 32'd1);
    applyStimulus(3'b001, 32'h200, 32'h260, 1'b0, 32'h204, 1'b0, 1'b0,
                  1'b0, 32'h0, 0, 1'b0, 1'b0);
    tick();
    checkOutput("flush_done", {31'd0, o_flush}, 32'd0);
    checkCounters("beq");
    checkPred(32'h100, 1'b1);
    checkPred(32'h200, 1'b0);

    $display("[TB] BLTU correctly predicted x3, then BGEU not taken");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b110, 32'h304, 32'h380, 1'b1, 32'h380, 1'b1, 1'b0,
                    1'b0, 32'h0, 0, 1'b0, 1'b1);
      checkOutput("bltu_no_flush", {31'd0, o_flush}, 32'd0);
    end
    checkPred(32'h304, 1'b1);
    applyStimulus(3'b111, 32'h304, 32'h380, 1'b0, 32'h308, 1'b1, 1'b0,
                  1'b0, 32'h0, 0, 1'b0, 1'b1);
    checkPred(32'h304, 1'b1);
    checkCounters("bltu");

    $display("[TB] BGE not taken at top of address space");
    applyStimulus(3'b101, 32'hFFFF_FFFC, 32'h10, 1'b1, 32'h10, 1'b1, 1'b0,
                  1'b1, 32'h0000_0000, FLUSH_CYC, 1'b0, 1'b1);
    tick();
    tick();
    checkCounters("bge");

    $display("[TB] illegal funct3 011 and 010");
    applyStimulus(3'b011, 32'h400, 32'h480, 1'b1, 32'h404, 1'b1, 1'b1,
                  1'b0, 32'h0, 0, 1'b1, 1'b0);
    applyStimulus(3'b010, 32'h400, 32'h480, 1'b0, 32'h404, 1'b0, 1'b0,
                  1'b0, 32'h0, 0, 1'b1, 1'b0);
    tick();
    checkCounters("illegal");
    checkPred(32'h400, 1'b0);

    $display("[TB] reset during first flush cycle");
    applyStimulus(3'b001, 32'h500, 32'h520, 1'b0, 32'h504, 1'b0, 1'b0,
                  1'b1, 32'h520, 1, 1'b0, 1'b1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    expBr = 0;
    expMis = 0;
    checkOutput("rst_in_flush_flush", {31'd0, o_flush}, 32'd0);
    checkCounters("rst_in_flush");
    checkPred(32'h100, 1'b0);
    checkPred(32'h304, 1'b0);
    tick();
    tick();

    checkOutput("redirect_queue_empty", 32'(redirQ.size()), 32'd0);
    checkOutput("flush_queue_empty", 32'(flushQ.size()), 32'd0);
    checkOutput("illegal_queue_empty", 32'(illQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
